// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the execute-stage operand source controller.
// Holds select encodings, the per-stage shadow record and small hazard helpers.
package ex_ctrl_pkg;

  localparam int EX_REG_ADDR_W = 5;
  localparam int EX_SEL_W      = 2;

  typedef enum logic [1:0] {
    SEL_REG  = 2'b00,
    SEL_PC   = 2'b01,
    SEL_ZERO = 2'b10
  } alu_in1_sel_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                     valid;
    logic [EX_REG_ADDR_W-1:0] rd;
    logic                     reg_write;
    logic                     mem_read;
  } stage_shadow_t;

  localparam logic [EX_REG_ADDR_W-1:0] REG_X0 = '0;

  function automatic stage_shadow_t shadow_bubble();
    stage_shadow_t s;
    s.valid     = 1'b0;
    s.rd        = REG_X0;
    s.reg_write = 1'b0;
    s.mem_read  = 1'b0;
    return s;
  endfunction

  // A stage can supply a source only if it really writes a non-x0 register.
  function automatic logic shadow_supplies(input logic                     valid,
                                           input logic                     reg_write,
                                           input logic [EX_REG_ADDR_W-1:0] rd,
                                           input logic                     used,
                                           input logic [EX_REG_ADDR_W-1:0] src);
    return valid && reg_write && (rd != REG_X0) && used && (rd == src);
  endfunction

  function automatic alu_in1_sel_e pick_in1(input logic use_pc, input logic use_zero);
    alu_in1_sel_e sel;
    sel = SEL_REG;
    if (use_pc) begin
      sel = SEL_PC;
    end else if (use_zero) begin
      sel = SEL_ZERO;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_operand_source_ctrl_fwd_match.sv
// Forwarding source decision for one ALU operand against the EX and MEM shadows.
// The younger (EX) producer takes precedence over the older (MEM) one.
module fwd_match
  import ex_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = EX_REG_ADDR_W,
  parameter int SEL_W      = EX_SEL_W
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_used,
  input  logic                  i_ex_valid,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_reg_write,
  input  logic                  i_mem_valid,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  output logic [SEL_W-1:0]      o_sel
);

  fwd_sel_e w_sel;
  logic     w_ex_hit;
  logic     w_mem_hit;

  always_comb begin
    w_ex_hit  = shadow_supplies(i_ex_valid, i_ex_reg_write, i_ex_rd, i_used, i_src);
    w_mem_hit = shadow_supplies(i_mem_valid, i_mem_reg_write, i_mem_rd, i_used, i_src);
    w_sel     = FWD_RF;
    if (w_ex_hit) begin
      w_sel = FWD_EXMEM;
    end else if (w_mem_hit) begin
      w_sel = FWD_MEMWB;
    end
  end

  assign o_sel = SEL_W'(w_sel);

endmodule

// File: rtl/ex_operand_source_ctrl.sv
// ALU operand source / forwarding select generator with load-use stall detection.
// Optional macro STALL_PERF_COUNTER_EN adds a 32-bit stall_count output.
module ex_operand_source_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = EX_REG_ADDR_W,
  parameter int SEL_W      = EX_SEL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_use_pc,
  input  logic                  id_use_zero,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      input1_select,
  output logic [SEL_W-1:0]      fwd_a_select,
  output logic [SEL_W-1:0]      fwd_b_select,
`ifdef STALL_PERF_COUNTER_EN
  output logic [31:0]           stall_count,
`endif
  output logic                  ex_valid
);

  stage_shadow_t          r_ex;
  stage_shadow_t          r_mem;
  stage_shadow_t          r_wb;
  stage_shadow_t          w_ex_next;
  logic [SEL_W-1:0]       r_input1_select;
  logic [SEL_W-1:0]       r_fwd_a_select;
  logic [SEL_W-1:0]       r_fwd_b_select;
  logic [SEL_W-1:0]       w_fwd_a;
  logic [SEL_W-1:0]       w_fwd_b;
  logic [SEL_W-1:0]       w_in1;
  logic                   w_load_dep;
  logic                   w_stall;
  logic                   w_advance;

  // Load in EX whose result the ID instruction needs: hold ID for one cycle.
  always_comb begin
    w_load_dep = ((id_rs1_used && (id_rs1 == r_ex.rd)) ||
                  (id_rs2_used && (id_rs2 == r_ex.rd)));
    w_stall    = !flush && id_valid && r_ex.valid && r_ex.mem_read &&
                 (r_ex.rd != REG_X0) && w_load_dep;
    w_advance  = id_valid && !w_stall && !flush;
  end

  always_comb begin
    w_ex_next = shadow_bubble();
    if (w_advance) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rd        = id_rd;
      w_ex_next.reg_write = id_reg_write;
      w_ex_next.mem_read  = id_mem_read;
    end
  end

  assign w_in1 = SEL_W'(pick_in1(id_use_pc, id_use_zero));

  fwd_match #(.REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) u_fwd_a (
    .i_src          (id_rs1),
    .i_used         (id_rs1_used),
    .i_ex_valid     (r_ex.valid),
    .i_ex_rd        (r_ex.rd),
    .i_ex_reg_write (r_ex.reg_write),
    .i_mem_valid    (r_mem.valid),
    .i_mem_rd       (r_mem.rd),
    .i_mem_reg_write(r_mem.reg_write),
    .o_sel          (w_fwd_a)
  );

  fwd_match #(.REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) u_fwd_b (
    .i_src          (id_rs2),
    .i_used         (id_rs2_used),
    .i_ex_valid     (r_ex.valid),
    .i_ex_rd        (r_ex.rd),
    .i_ex_reg_write (r_ex.reg_write),
    .i_mem_valid    (r_mem.valid),
    .i_mem_rd       (r_mem.rd),
    .i_mem_reg_write(r_mem.reg_write),
    .o_sel          (w_fwd_b)
  );

  // Selects are captured with the instruction so they hold for its whole EX cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex            <= shadow_bubble();
      r_mem           <= shadow_bubble();
      r_wb            <= shadow_bubble();
      r_input1_select <= '0;
      r_fwd_a_select  <= '0;
      r_fwd_b_select  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_ex_next;
      if (w_advance) begin
        r_input1_select <= w_in1;
        r_fwd_a_select  <= w_fwd_a;
        r_fwd_b_select  <= w_fwd_b;
      end else begin
        r_input1_select <= '0;
        r_fwd_a_select  <= '0;
        r_fwd_b_select  <= '0;
      end
    end
  end

`ifdef STALL_PERF_COUNTER_EN
  logic [31:0] r_stall_count;

  // w_stall is already masked by flush, so redirect cycles never count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

  assign stall         = w_stall;
  assign input1_select = r_input1_select;
  assign fwd_a_select  = r_fwd_a_select;
  assign fwd_b_select  = r_fwd_b_select;
  assign ex_valid      = r_ex.valid;

endmodule

// File: tb/tb_ex_operand_source_ctrl.sv
// Bench for ex_operand_source_ctrl: directed hazard cases plus random traffic
// checked against a history-of-issued-instructions reference model.
module tb_ex_operand_source_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_use_pc, id_use_zero;
  logic       id_reg_write, id_mem_read, flush;
  logic       stall;
  logic [1:0] input1_select, fwd_a_select, fwd_b_select;
  logic       ex_valid;
`ifdef STALL_PERF_COUNTER_EN
  logic [31:0] stall_count;
  int unsigned exp_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ex_operand_source_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_use_pc    (id_use_pc),
    .id_use_zero  (id_use_zero),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .input1_select(input1_select),
    .fwd_a_select (fwd_a_select),
    .fwd_b_select (fwd_b_select),
`ifdef STALL_PERF_COUNTER_EN
    .stall_count  (stall_count),
`endif
    .ex_valid     (ex_valid)
  );

  always #5 clk = ~clk;

  // Reference model: the two most recent instructions that entered EX.
  // age 0 = the one now in EX, age 1 = the one now in MEM; bubbles are invalid.
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
  } issued_t;

  issued_t hist [2];
  bit [1:0] exp_in1, exp_fa, exp_fb;
  bit       exp_exv;
  bit       obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest in-flight writer of src wins; the age encodes the select value.
  function automatic bit [1:0] model_fwd(input bit [4:0] src, input bit used);
    if (!used || src == 5'd0) return 2'd0;
    for (int age = 0; age < 2; age++) begin
      if (hist[age].valid && hist[age].rw && hist[age].rd == src)
        return 2'(age + 1);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) hist[k] = '{valid: 0, rd: 0, rw: 0, ld: 0};
    exp_in1 = 0; exp_fa = 0; exp_fb = 0; exp_exv = 0;
`ifdef STALL_PERF_COUNTER_EN
    exp_cnt = 0;
`endif
  endtask

  task automatic cyc(input bit v, input bit [4:0] rs1, input bit u1,
                     input bit [4:0] rs2, input bit u2, input bit pc, input bit zr,
                     input bit [4:0] rd, input bit rw, input bit ld, input bit fl);
    bit e_stall, adv;
    issued_t nx;
    @(negedge clk);
    check("in1_sel", 32'(input1_select), 32'(exp_in1));
    check("fwd_a",   32'(fwd_a_select),  32'(exp_fa));
    check("fwd_b",   32'(fwd_b_select),  32'(exp_fb));
    check("ex_valid",32'(ex_valid),      32'(exp_exv));
`ifdef STALL_PERF_COUNTER_EN
    check("stall_count", stall_count, exp_cnt);
`endif
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_use_pc = pc; id_use_zero = zr; id_rd = rd; id_reg_write = rw;
    id_mem_read = ld; flush = fl;
    #1;
    e_stall = !fl && v && hist[0].valid && hist[0].ld && hist[0].rd != 0 &&
              ((u1 && rs1 == hist[0].rd) || (u2 && rs2 == hist[0].rd));
    obs_stall = stall;
    check("stall", 32'(stall), 32'(e_stall));
    adv     = v && !e_stall && !fl;
    exp_in1 = !adv ? 2'd0 : pc ? 2'd1 : zr ? 2'd2 : 2'd0;
    exp_fa  = adv ? model_fwd(rs1, u1) : 2'd0;
    exp_fb  = adv ? model_fwd(rs2, u2) : 2'd0;
    exp_exv = adv;
`ifdef STALL_PERF_COUNTER_EN
    if (e_stall) exp_cnt++;
`endif
    nx = '{valid: adv, rd: adv ? rd : 5'd0, rw: adv && rw, ld: adv && ld};
    hist[1] = hist[0];
    hist[0] = nx;
  endtask

  // Wait until the registered selects of the last issued cycle are visible.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
    cyc(1, rs1, 1, rs2, 1, 0, 0, rd, 1, 0, 0);
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_use_pc = 0; id_use_zero = 0;
    id_reg_write = 0; id_mem_read = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in1", 32'(input1_select), 0);
    check("rst_fwd_a", 32'(fwd_a_select), 0);
    check("rst_fwd_b", 32'(fwd_b_select), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_ex_valid", 32'(ex_valid), 0);
    @(negedge clk);
    reset = 0;

    // ADD x5; ADD x6,x5,x1
    alu(5, 1, 2); alu(6, 5, 1); settle();
    check("b2b_fwd_a", 32'(fwd_a_select), 1);
    check("b2b_fwd_b", 32'(fwd_b_select), 0);

    // ADD x5; NOP; SUB x7,x2,x5
    alu(5, 1, 2); nop(); alu(7, 2, 5); settle();
    check("gap_fwd_b", 32'(fwd_b_select), 2);

    // ADD x5; ADD x5; OR x8,x5,x5
    alu(5, 1, 2); alu(5, 3, 4); alu(8, 5, 5); settle();
    check("exwins_a", 32'(fwd_a_select), 1);
    check("exwins_b", 32'(fwd_b_select), 1);

    // LW x9; ADD x10,x9,x0 (held one cycle, then forwarded from MEM/WB)
    cyc(1, 1, 1, 0, 0, 0, 0, 9, 1, 1, 0);
    cyc(1, 9, 1, 0, 1, 0, 0, 10, 1, 0, 0);
    check("ldu_stall", 32'(obs_stall), 1);
    settle();
    check("ldu_bubble", 32'(ex_valid), 0);
    cyc(1, 9, 1, 0, 1, 0, 0, 10, 1, 0, 0);
    check("ldu_one_cycle", 32'(obs_stall), 0);
    settle();
    check("ldu_fwd_a", 32'(fwd_a_select), 2);

    // LW x0; ADD x10,x0,x0
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 10, 1, 0, 0);
    check("ldx0_stall", 32'(obs_stall), 0);
    settle();
    check("ldx0_fwd_a", 32'(fwd_a_select), 0);

    // AUIPC, LUI, both flags
    cyc(1, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0); settle();
    check("auipc_in1", 32'(input1_select), 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0); settle();
    check("lui_in1", 32'(input1_select), 2);
    cyc(1, 0, 0, 0, 0, 1, 1, 3, 1, 0, 0); settle();
    check("pc_wins_in1", 32'(input1_select), 1);

    // Load-use coinciding with flush
    cyc(1, 1, 1, 0, 0, 0, 0, 12, 1, 1, 0);
    cyc(1, 12, 1, 12, 1, 1, 0, 13, 1, 0, 1);
    check("flush_stall", 32'(obs_stall), 0);
    settle();
    check("flush_ex_valid", 32'(ex_valid), 0);
    check("flush_in1", 32'(input1_select), 0);
    check("flush_fwd_a", 32'(fwd_a_select), 0);

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 7) != 0,
          5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    nop();
    nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
